// File: rtl/logic_unit_serial_if.sv
// logic_unit_serial_if: request/result bundle for the serial logic unit.
//   master drives: start, op, A, B
//   slave drives:  busy, done, Result, zero, parity
// WIDTH must match the WIDTH of the logic_unit_serial instance it is attached to.
interface logic_unit_serial_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             zero;
    logic             parity;

    modport master (
        output start, op, A, B,
        input  busy, done, Result, zero, parity
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, Result, zero, parity
    );
endinterface

// File: rtl/logic_unit_serial.sv
// logic_unit_serial: multi-cycle bitwise logic unit.
// Operands are latched on start (in IDLE) and one CHUNK-bit slice is processed per
// clock, LSB slice first, through a single shared CHUNK-bit logic core. The final
// result is registered together with zero/parity flags and announced by a one-cycle
// done strobe.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of logic_unit_serial_if (start/op/A/B in,
//          busy/done/Result/zero/parity out)
// op: 000 XOR, 001 AND, 010 OR, 011 XNOR, 100 NAND, 101 NOR, 110 NOT A, 111 pass A.
// WIDTH must be a multiple of CHUNK.
module logic_unit_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input logic               clk,
    input logic               rst,
    logic_unit_serial_if.slave bus
);

    localparam int unsigned N = WIDTH / CHUNK;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;

    logic [CHUNK-1:0] a_slice, b_slice, res_slice;
    logic             last;

    // Shared CHUNK-bit logic core; slices never interact, so this is the whole datapath.
    function automatic logic [CHUNK-1:0] core(input logic [2:0] sel,
                                              input logic [CHUNK-1:0] x,
                                              input logic [CHUNK-1:0] y);
        logic [CHUNK-1:0] r;
        case (sel)
            3'b000:  r = x ^ y;
            3'b001:  r = x & y;
            3'b010:  r = x | y;
            3'b011:  r = ~(x ^ y);
            3'b100:  r = ~(x & y);
            3'b101:  r = ~(x | y);
            3'b110:  r = ~x;
            default: r = x;
        endcase
        return r;
    endfunction

    assign a_slice   = a_q[cnt_q*CHUNK +: CHUNK];
    assign b_slice   = b_q[cnt_q*CHUNK +: CHUNK];
    assign res_slice = core(op_q, a_slice, b_slice);
    assign last      = (cnt_q == CntLast);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.busy   = (state_q == StRun);
        bus.done   = (state_q == StDone);
        bus.Result = result_q;
        bus.zero   = zero_q;
        bus.parity = parity_q;
    end

    // Datapath next-state
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        result_d = result_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d   = bus.op;
                    a_d    = bus.A;
                    b_d    = bus.B;
                    work_d = '0;
                    cnt_d  = '0;
                end
            end
            StRun: begin
                work_d[cnt_q*CHUNK +: CHUNK] = res_slice;
                cnt_d = last ? '0 : cnt_q + 1'b1;
                // Flags come from the completed word including the slice written this edge.
                if (last) begin
                    result_d = work_d;
                    zero_d   = ~|work_d;
                    parity_d = ^work_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

endmodule

// File: tb/tb_logic_unit_serial.sv
// Testbench for logic_unit_serial: a 16/4 instance checked every cycle against a
// timeline model, plus an 8/8 (single-slice) instance checked by directed and random runs.
module tb_logic_unit_serial;

    localparam int N = 4;  // 16 / 4 slices

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic_unit_serial_if #(.WIDTH(16)) bus16 ();
    logic_unit_serial_if #(.WIDTH(8))  bus8 ();

    logic_unit_serial #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    logic_unit_serial #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full-width combinational meaning of each op.
    function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        case (op)
            3'd0:    return a ^ b;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return ~(a ^ b);
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // Timeline model of the 16/4 instance: a request accepted in cycle t0 means
    // busy in t0+1..t0+N, done in t0+N+1, new Result from t0+N+1, next accept at t0+N+2.
    int          cyc = 0;
    int          t0 = 0;
    bit          flight = 1'b0;
    bit          armed = 1'b0;
    logic [15:0] pend = '0;
    logic [15:0] exp_res = '0;
    int          dones16 = 0;

    always @(posedge clk) begin
        if (rst) begin
            flight  = 1'b0;
            exp_res = '0;
        end else if (bus16.start && (!flight || cyc >= t0 + N + 2)) begin
            flight = 1'b1;
            t0     = cyc;
            pend   = ref_op(bus16.op, bus16.A, bus16.B);
        end
        cyc++;
        if (flight && cyc == t0 + N + 1) exp_res = pend;
        armed = 1'b1;
    end

    logic exp_busy, exp_done;
    always @(negedge clk) begin
        if (armed) begin
            exp_busy = flight && cyc >= t0 + 1 && cyc <= t0 + N;
            exp_done = flight && cyc == t0 + N + 1;
            chk("m_busy", bus16.busy, exp_busy);
            chk("m_done", bus16.done, exp_done);
            chk("m_result", bus16.Result, exp_res);
            chk("m_zero", bus16.zero, exp_res == 16'h0);
            chk("m_parity", bus16.parity, ^exp_res);
            if (bus16.done === 1'b1) dones16++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input logic s, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b);
        bus16.start = s;
        bus16.op    = op;
        bus16.A     = a;
        bus16.B     = b;
    endtask

    // Starts from IDLE and returns in the first cycle a new start can be accepted.
    task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        drive16(1'b1, op, a, b);
        tick();
        bus16.start = 1'b0;
        for (int i = 0; i < N + 4 && bus16.done !== 1'b1; i++) tick();
        chk("run16_done_seen", bus16.done, 1'b1);
        tick();
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] full;
        logic [7:0]  e;
        full = ref_op(op, {8'h00, a}, {8'h00, b});
        e    = full[7:0];
        bus8.start = 1'b1;
        bus8.op    = op;
        bus8.A     = a;
        bus8.B     = b;
        tick();
        bus8.start = 1'b0;
        bus8.A     = ~a;
        chk("n1_busy_t1", bus8.busy, 1'b1);
        chk("n1_done_t1", bus8.done, 1'b0);
        tick();
        chk("n1_busy_t2", bus8.busy, 1'b0);
        chk("n1_done_t2", bus8.done, 1'b1);
        chk("n1_result", bus8.Result, e);
        chk("n1_zero", bus8.zero, e == 8'h00);
        chk("n1_parity", bus8.parity, ^e);
        tick();
        chk("n1_done_t3", bus8.done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        drive16(1'b0, 3'd0, 16'h0, 16'h0);
        bus8.start = 1'b0;
        bus8.op    = 3'd0;
        bus8.A     = 8'h0;
        bus8.B     = 8'h0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        chk("rst_busy", bus16.busy, 1'b0);
        chk("rst_done", bus16.done, 1'b0);
        chk("rst_result", bus16.Result, 16'h0000);
        chk("rst_zero", bus16.zero, 1'b1);
        chk("rst_parity", bus16.parity, 1'b0);
        chk("rst8_result", bus8.Result, 8'h00);
        chk("rst8_zero", bus8.zero, 1'b1);

        // XOR with full timing
        drive16(1'b1, 3'b000, 16'hA5F0, 16'hFF0F);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) bus16.start = 1'b0;
            chk("xor_busy", bus16.busy, k <= 4);
            chk("xor_done", bus16.done, k == 5);
            if (k <= 4) chk("xor_hold", bus16.Result, 16'h0000);
        end
        chk("xor_result", bus16.Result, 16'h5AFF);
        chk("xor_zero", bus16.zero, 1'b0);
        chk("xor_parity", bus16.parity, 1'b0);
        tick();

        // Zero and parity flags
        run16(3'b000, 16'h1234, 16'h1234);
        chk("zp1_result", bus16.Result, 16'h0000);
        chk("zp1_zero", bus16.zero, 1'b1);
        chk("zp1_parity", bus16.parity, 1'b0);
        run16(3'b110, 16'h00FE, 16'hBEEF);
        chk("zp2_result", bus16.Result, 16'hFF01);
        chk("zp2_zero", bus16.zero, 1'b0);
        chk("zp2_parity", bus16.parity, 1'b1);

        // Ignored requests and operand isolation
        drive16(1'b1, 3'b001, 16'hF0F0, 16'hFFFF);
        for (int k = 1; k <= 11; k++) begin
            tick();
            case (k)
                1: begin
                    bus16.start = 1'b0;
                    bus16.A     = 16'h1234;
                end
                2: drive16(1'b1, 3'b010, 16'h0F0F, 16'h3333);
                3: bus16.start = 1'b0;
                5: drive16(1'b1, 3'b010, 16'h0F0F, 16'h3333);
                7: bus16.start = 1'b0;
                default: ;
            endcase
            chk("ign_done", bus16.done, (k == 5) || (k == 11));
            if (k == 5) chk("ign_result1", bus16.Result, 16'hF0F0);
            if (k == 11) chk("ign_result2", bus16.Result, 16'h3F3F);
        end
        tick();

        // Reset mid-operation
        run16(3'b000, 16'hA5F0, 16'hFF0F);
        chk("pre_rst_result", bus16.Result, 16'h5AFF);
        drive16(1'b1, 3'b100, 16'hFFFF, 16'h0F0F);
        tick();
        bus16.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", bus16.busy, 1'b0);
        chk("mrst_done", bus16.done, 1'b0);
        chk("mrst_result", bus16.Result, 16'h0000);
        chk("mrst_zero", bus16.zero, 1'b1);
        chk("mrst_parity", bus16.parity, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mrst_no_done", bus16.done, 1'b0);
        end
        run16(3'b100, 16'hFFFF, 16'h0F0F);
        chk("after_rst_result", bus16.Result, 16'hF0F0);
        chk("after_rst_parity", bus16.parity, 1'b0);

        // Free-running random traffic on the 16/4 instance, judged by the model
        dones16 = 0;
        for (int i = 0; i < 700; i++) begin
            bus16.start = ($urandom_range(0, 2) == 0);
            bus16.op    = 3'($urandom_range(0, 7));
            bus16.A     = 16'($urandom);
            bus16.B     = 16'($urandom);
            rst         = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        bus16.start = 1'b0;
        tick();
        chk("rand_activity", dones16 >= 40, 1'b1);

        // Single-slice instance
        run8(3'b101, 8'h0F, 8'h30);
        chk("nor_result", bus8.Result, 8'hC0);
        chk("nor_parity", bus8.parity, 1'b0);
        for (int i = 0; i < 24; i++) begin
            run8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
